fifo_sc_fwft_m: RTL and testbench

- Parametrised single-clock, first-word-fall-through FIFO with inferred storage, so it carries no vendor primitive.
- Adds fill-level reporting, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags.
- Serves as the general buffering element between pipeline stages within one clock domain.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_ram_sdp_m.sv | 32 +++
 rtl/fifo_sc_fwft_m.sv | 108 ++++++++++
 tb/tb_fifo_sc_fwft_m.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FWFT FIFO and its storage.
package fifo_pkg;

    localparam string MEMTYPE_AUTO        = "auto";
    localparam string MEMTYPE_DISTRIBUTED = "distributed";
    localparam string MEMTYPE_BLOCK       = "block";

    localparam int MAX_DEPTH = 4096;

    // Never returns 0, so a 2-entry FIFO still gets a 1-bit pointer.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int count_width(input int depth);
        return clog2_safe(depth) + 1;
    endfunction

    typedef logic [$clog2(MAX_DEPTH):0] count_max_t;

endpackage

// File: rtl/fifo_ram_sdp_m.sv
// Simple dual-port RAM: synchronous write, asynchronous read (needed for exact FWFT head).
module fifo_ram_sdp_m
    import fifo_pkg::*;
#(
    parameter type   DATA_ITEM_TYPE = logic,
    parameter int    DEPTH          = 32,
    parameter string MEMTYPE        = MEMTYPE_AUTO,
    localparam int   AW             = clog2_safe(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  DATA_ITEM_TYPE wdata,
    input  logic [AW-1:0] raddr,
    output DATA_ITEM_TYPE rdata
);

    if (MEMTYPE != MEMTYPE_AUTO && MEMTYPE != MEMTYPE_DISTRIBUTED && MEMTYPE != MEMTYPE_BLOCK) begin : g_bad_memtype
        $error("fifo_ram_sdp_m: MEMTYPE must be auto, distributed or block");
    end

    (* ram_style = MEMTYPE *) DATA_ITEM_TYPE mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sc_fwft_m.sv
// Single-clock first-word-fall-through FIFO with level flags, flush and sticky error flags.
module fifo_sc_fwft_m
    import fifo_pkg::*;
#(
    parameter type   DATA_ITEM_TYPE = logic,
    parameter int    DEPTH          = 32,
    parameter int    AFULL_THRESH   = DEPTH - 2,
    parameter int    AEMPTY_THRESH  = 2,
    parameter string MEMTYPE        = MEMTYPE_AUTO
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  DATA_ITEM_TYPE         tail,
    input  logic                  push,
    output DATA_ITEM_TYPE         head,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = clog2_safe(DEPTH);
    typedef logic [count_width(DEPTH)-1:0] count_t;

    if (DEPTH < 2 || DEPTH > MAX_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sc_fwft_m: DEPTH must be a power of two in 2..4096");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_sc_fwft_m: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sc_fwft_m: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    count_t        count_q;
    logic          do_push;
    logic          do_pop;

    // Acceptance uses only registered flags, so full/empty never see push/pop combinationally.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign count        = count_q;
    assign full         = (count_q == count_t'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= count_t'(AFULL_THRESH));
    assign almost_empty = (count_q <= count_t'(AEMPTY_THRESH));

    fifo_ram_sdp_m #(
        .DATA_ITEM_TYPE (DATA_ITEM_TYPE),
        .DEPTH          (DEPTH),
        .MEMTYPE        (MEMTYPE)
    ) u_ram (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (tail),
        .raddr (rd_ptr),
        .rdata (head)
    );

    a_push_while_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
        else $warning("fifo_sc_fwft_m: push while full, item dropped");
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count_q <= count_t'(DEPTH));
    a_full_and_empty: assert property (@(posedge clk) disable iff (!rst_n) !(full && empty));

endmodule

// File: tb/tb_fifo_sc_fwft_m.sv
// Bench for fifo_sc_fwft_m: directed scenarios plus random traffic against a queue model.
module tb_fifo_sc_fwft_m;

    localparam int DEPTH = 32;
    localparam int AFT   = DEPTH - 2;
    localparam int AET   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [7:0] tail;
    logic       push;
    logic       pop;
    logic [7:0] head;
    logic       full, empty, almost_full, almost_empty;
    logic [5:0] count;
    logic       overflow, underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit         m_ov = 1'b0;
    bit         m_un = 1'b0;

    fifo_sc_fwft_m #(
        .DATA_ITEM_TYPE (logic [7:0]),
        .DEPTH          (DEPTH),
        .AFULL_THRESH   (AFT),
        .AEMPTY_THRESH  (AET),
        .MEMTYPE        ("auto")
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .tail         (tail),
        .push         (push),
        .head         (head),
        .pop          (pop),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Model: flags come from occupancy before the edge; pop consumes the oldest item.
    task automatic model_edge(input bit p, input bit po, input bit f, input logic [7:0] d);
        int n;
        n = q.size();
        if (f) begin
            q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            if (po) begin
                if (n == 0) m_un = 1'b1;
                else        void'(q.pop_front());
            end
            if (p) begin
                if (n == DEPTH) m_ov = 1'b1;
                else            q.push_back(d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", int'(count), q.size());
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("full", int'(full), int'(q.size() == DEPTH));
            chk("almost_full", int'(almost_full), int'(q.size() >= AFT));
            chk("almost_empty", int'(almost_empty), int'(q.size() <= AET));
            chk("overflow", int'(overflow), int'(m_ov));
            chk("underflow", int'(underflow), int'(m_un));
            if (q.size() > 0) chk("head", int'(head), int'(q[0]));
        end
    end

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cyc(input bit p, input bit po, input bit f, input logic [7:0] d);
        push  = p;
        pop   = po;
        flush = f;
        tail  = d;
        @(posedge clk);
        model_edge(p, po, f, d);
        @(negedge clk);
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_almost_empty"}, int'(almost_empty), 1);
        chk({tag, "_almost_full"}, int'(almost_full), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_underflow"}, int'(underflow), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        tail  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Fill 0x01..0x20; almost_full first seen at 30 entries.
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(i));
            chk("fill_count", int'(count), i);
            chk("fill_afull", int'(almost_full), int'(i >= 30));
        end
        chk("filled_full", int'(full), 1);
        chk("filled_overflow", int'(overflow), 0);

        // Drain in order; almost_empty first seen at 2 entries.
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_head", int'(head), i + 1);
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            chk("drain_aempty", int'(almost_empty), int'((31 - i) <= 2));
        end
        chk("drained_empty", int'(empty), 1);
        chk("drained_underflow", int'(underflow), 0);

        // Steady state at 5 entries across many pointer wraps.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
        chk("steady_count", int'(count), 5);

        // Push on full while popping: pop wins, push dropped.
        for (int i = 0; i < DEPTH - 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
        chk("refill_full", int'(full), 1);
        cyc(1'b1, 1'b1, 1'b0, 8'hEE);
        chk("push_full_overflow", int'(overflow), 1);
        chk("push_full_count", int'(count), 31);

        // Pop on empty while pushing: push accepted, underflow flagged.
        for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'h77);
        chk("pop_empty_underflow", int'(underflow), 1);
        chk("pop_empty_count", int'(count), 1);
        chk("pop_empty_head", int'(head), 8'h77);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);

        // Single item falls through after exactly one edge.
        cyc(1'b1, 1'b0, 1'b0, 8'hA5);
        chk("fwft_empty", int'(empty), 0);
        chk("fwft_head", int'(head), 8'hA5);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("fwft_pop_empty", int'(empty), 1);

        // Flush with a concurrent push: push ignored, error flags cleared.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        chk("preflush_count", int'(count), 10);
        cyc(1'b1, 1'b0, 1'b1, 8'hCC);
        check_reset_values("flush");

        // Asynchronous reset mid-cycle at 7 entries.
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        chk("prereset_count", int'(count), 7);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        q.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with phase-varying push bias to visit full and empty.
        for (int i = 0; i < 800; i++) begin
            int bias;
            bit p, po, f;
            bias = ((i / 100) % 2 == 0) ? 75 : 25;
            p  = ($urandom_range(0, 99) < bias);
            po = ($urandom_range(0, 99) < (100 - bias));
            f  = ($urandom_range(0, 199) == 0);
            cyc(p, po, f, 8'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
